// File: rtl/seven_seg_pkg.sv
// seven_seg_pkg
// Shared types and constants for the seven-segment display slice.
//   seg_t         : 7-bit segment vector, bit 0 = segment a ... bit 6 = segment g
//   SEG_BLANK     : active-low cathode pattern with every segment dark
//   HEX_SEG_TABLE : active-high segment pattern for each hex digit 0..F
package seven_seg_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_BLANK = 7'h7F;

  // Lower-case b and d keep 8/B and 0/D distinguishable.
  localparam seg_t HEX_SEG_TABLE [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

endpackage

// File: rtl/hex_to_7seg.sv
// hex_to_7seg
// Combinational hex nibble to seven-segment decoder.
// The output is active-high; the caller inverts it for common-anode cathodes.
//   hex : input  [3:0] nibble to decode
//   seg : output seg_t segments a..g at bits 0..6, 1 = lit
module hex_to_7seg
  import seven_seg_pkg::*;
(
  input  logic [3:0] hex,
  output seg_t       seg
);

  assign seg = HEX_SEG_TABLE[hex];

endmodule

// File: rtl/seven_segment_controller.sv
// seven_segment_controller
// Time-multiplexed driver for NUM_DIGITS common-anode seven-segment digits.
// New values are captured into a shadow buffer on valid_in and copied to the
// display buffer only at a frame boundary, so a frame never mixes two values.
// All outputs are registered and lag the counter/index/display state by one cycle.
//
// Parameters:
//   NUM_DIGITS   : digits scanned (1..16)
//   COUNT_PERIOD : clock cycles per digit slot (>= 2)
//   BLANK_CYCLES : anode-off cycles at the start of each slot (0 disables)
// Ports:
//   clk_in    : input  system clock
//   rst_in    : input  synchronous active-high reset
//   val_in    : input  [4*NUM_DIGITS-1:0] hex nibbles, nibble i -> digit i
//   en_in     : input  [NUM_DIGITS-1:0] per-digit enable
//   dp_in     : input  [NUM_DIGITS-1:0] per-digit decimal point, 1 = lit
//   valid_in  : input  capture val_in/en_in/dp_in this cycle
//   an_out    : output [NUM_DIGITS-1:0] anodes, active-low, at most one low
//   cat_out   : output [6:0] cathodes a..g, active-low
//   dp_out    : output decimal-point cathode, active-low
//   frame_out : output one-cycle pulse after each frame boundary
// Optional feature macro: LEADING_ZERO_BLANK_EN (suppresses leading zeros).
module seven_segment_controller
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS   = 8,
  parameter int COUNT_PERIOD = 100000,
  parameter int BLANK_CYCLES = 0
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic [4*NUM_DIGITS-1:0] val_in,
  input  logic [NUM_DIGITS-1:0]   en_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    valid_in,
  output logic [NUM_DIGITS-1:0]   an_out,
  output logic [6:0]              cat_out,
  output logic                    dp_out,
  output logic                    frame_out
);

  localparam int CW = $clog2(COUNT_PERIOD);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(COUNT_PERIOD - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

  logic [CW-1:0]           slot_cnt;
  logic [IW-1:0]           digit_idx;
  logic [4*NUM_DIGITS-1:0] shadow_val, disp_val;
  logic [NUM_DIGITS-1:0]   shadow_en, disp_en;
  logic [NUM_DIGITS-1:0]   shadow_dp, disp_dp;
  logic                    pending;

  logic slot_end, frame_end, in_blank;
  logic [3:0] cur_nibble;
  seg_t cur_seg;
  logic suppress, show_seg, show_anode;

  assign slot_end  = (slot_cnt == CNT_LAST);
  assign frame_end = slot_end && (digit_idx == IDX_LAST);

  // With no blanking configured the comparison would be constant, so it is
  // removed at elaboration instead.
  if (BLANK_CYCLES > 0) begin : g_blank
    assign in_blank = (slot_cnt < CW'(BLANK_CYCLES));
  end else begin : g_no_blank
    assign in_blank = 1'b0;
  end

  // Slot counter and digit index; the index steps once per completed slot.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      slot_cnt  <= '0;
      digit_idx <= '0;
    end else if (slot_end) begin
      slot_cnt  <= '0;
      digit_idx <= (digit_idx == IDX_LAST) ? '0 : digit_idx + 1'b1;
    end else begin
      slot_cnt <= slot_cnt + 1'b1;
    end
  end

  // Double buffer. A valid_in on the boundary cycle itself goes straight to
  // the display so it is not delayed by a whole frame.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      shadow_val <= '0;
      shadow_en  <= '0;
      shadow_dp  <= '0;
      disp_val   <= '0;
      disp_en    <= '0;
      disp_dp    <= '0;
      pending    <= 1'b0;
    end else begin
      if (valid_in) begin
        shadow_val <= val_in;
        shadow_en  <= en_in;
        shadow_dp  <= dp_in;
      end
      if (frame_end) begin
        pending <= 1'b0;
        if (valid_in) begin
          disp_val <= val_in;
          disp_en  <= en_in;
          disp_dp  <= dp_in;
        end else if (pending) begin
          disp_val <= shadow_val;
          disp_en  <= shadow_en;
          disp_dp  <= shadow_dp;
        end
      end else if (valid_in) begin
        pending <= 1'b1;
      end
    end
  end

  assign cur_nibble = disp_val[{digit_idx, 2'b00} +: 4];

  hex_to_7seg u_dec (
    .hex (cur_nibble),
    .seg (cur_seg)
  );

`ifdef LEADING_ZERO_BLANK_EN
  logic [NUM_DIGITS-1:0] lz_blank;

  // Walk from the most significant digit down; disabled digits do not break
  // the run of leading zeros. Digit 0 is never suppressed.
  always_comb begin
    logic zero_above;
    zero_above = 1'b1;
    lz_blank   = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      if ((i != 0) && zero_above && (disp_val[4*i +: 4] == 4'h0)) begin
        lz_blank[i] = 1'b1;
      end
      if (disp_en[i]) begin
        zero_above = zero_above && (disp_val[4*i +: 4] == 4'h0);
      end
    end
  end

  assign suppress = lz_blank[digit_idx];
`else
  assign suppress = 1'b0;
`endif

  // A suppressed digit keeps its anode on only to light its decimal point.
  assign show_seg   = disp_en[digit_idx] && !suppress;
  assign show_anode = disp_en[digit_idx] && (!suppress || disp_dp[digit_idx]) && !in_blank;

  // Registered output stage; cathodes ignore blanking so only anodes and dp gate.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      an_out    <= '1;
      cat_out   <= SEG_BLANK;
      dp_out    <= 1'b1;
      frame_out <= 1'b0;
    end else begin
      an_out    <= show_anode ? ~(NUM_DIGITS'(1) << digit_idx) : '1;
      cat_out   <= show_seg ? ~cur_seg : SEG_BLANK;
      dp_out    <= !(show_anode && disp_dp[digit_idx]);
      frame_out <= frame_end;
    end
  end

endmodule

// File: tb/tb_seven_segment_controller.sv
// tb_seven_segment_controller
// Directed bench for seven_segment_controller with 4 digits, 8-cycle slots and
// 2 blanking cycles. Inputs are driven and outputs sampled 1 time unit after
// the rising edge; an independent monitor checks the anode one-hot rule on
// every falling edge.
module tb_seven_segment_controller;

  localparam int ND = 4;
  localparam int CP = 8;
  localparam int BC = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] val;
  logic [3:0]  en;
  logic [3:0]  dp;
  logic        valid;
  logic [3:0]  an;
  logic [6:0]  cat;
  logic        dp_o;
  logic        frame;

  int checks = 0;
  int passed = 0;
  int pos    = 0;
  bit mon_on = 1'b0;

  typedef struct {
    logic [15:0] v;
    logic [3:0]  e;
    logic [3:0]  d;
    int          digit;
    logic [3:0]  an;
    logic [6:0]  cat;
    logic        dpo;
  } vec_t;

  vec_t tbl [17];

  seven_segment_controller #(
    .NUM_DIGITS   (ND),
    .COUNT_PERIOD (CP),
    .BLANK_CYCLES (BC)
  ) dut (
    .clk_in    (clk),
    .rst_in    (rst),
    .val_in    (val),
    .en_in     (en),
    .dp_in     (dp),
    .valid_in  (valid),
    .an_out    (an),
    .cat_out   (cat),
    .dp_out    (dp_o),
    .frame_out (frame)
  );

  always #5 clk = ~clk;

  // At most one anode may ever be driven low.
  always @(negedge clk) begin
    if (mon_on) begin
      checks++;
      if ($countones(~an) <= 1) passed++;
      else $display("[TB] FAIL an_onehot: an=%b required at most one low", an);
    end
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s: got %0h required %0h", name, act, exp);
  endtask

  task automatic check_all(input string name, input logic [3:0] e_an, input logic [6:0] e_cat, input logic e_dp);
    check_output({name, "_an"}, 32'(an), 32'(e_an));
    check_output({name, "_cat"}, 32'(cat), 32'(e_cat));
    check_output({name, "_dp"}, 32'(dp_o), 32'(e_dp));
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) @(posedge clk);
    #1;
    pos += n;
  endtask

  // Advance to the sample point whose outputs reflect slot (digit, cyc) of the
  // frame that began at the last frame_out.
  task automatic goto_slot(input int digit, input int cyc);
    int target;
    target = 1 + CP * digit + cyc;
    if (target > pos) step(target - pos);
  endtask

  task automatic wait_frame(output int k);
    k = 0;
    do begin
      step(1);
      k++;
    end while (!frame && k < 100);
    check_output("frame_seen", 32'(frame), 32'd1);
    pos = 0;
  endtask

  task automatic apply_stimulus(input logic [15:0] v, input logic [3:0] e, input logic [3:0] d);
    val   = v;
    en    = e;
    dp    = d;
    valid = 1'b1;
    step(1);
    valid = 1'b0;
  endtask

  initial begin
    int k;
    bit seen1;

    tbl[0]  = '{16'h12AF, 4'hF, 4'b0100, 0, 4'hE, 7'h0E, 1'b1};
    tbl[1]  = '{16'h12AF, 4'hF, 4'b0100, 1, 4'hD, 7'h08, 1'b1};
    tbl[2]  = '{16'h12AF, 4'hF, 4'b0100, 2, 4'hB, 7'h24, 1'b0};
    tbl[3]  = '{16'h12AF, 4'hF, 4'b0100, 3, 4'h7, 7'h79, 1'b1};
    tbl[4]  = '{16'h3456, 4'hF, 4'b0000, 0, 4'hE, 7'h02, 1'b1};
    tbl[5]  = '{16'h7890, 4'hF, 4'b0000, 1, 4'hD, 7'h10, 1'b1};
    tbl[6]  = '{16'hCDE8, 4'hF, 4'b0000, 3, 4'h7, 7'h46, 1'b1};
    tbl[7]  = '{16'hCDE8, 4'hF, 4'b0000, 2, 4'hB, 7'h21, 1'b1};
    tbl[8]  = '{16'hCDE8, 4'hF, 4'b0000, 1, 4'hD, 7'h06, 1'b1};
    tbl[9]  = '{16'h1234, 4'b1010, 4'hF, 0, 4'hF, 7'h7F, 1'b1};
    tbl[10] = '{16'h1234, 4'b1010, 4'hF, 1, 4'hD, 7'h30, 1'b0};
    tbl[11] = '{16'h0004, 4'b0001, 4'b0000, 0, 4'hE, 7'h19, 1'b1};
    tbl[12] = '{16'h5000, 4'b1000, 4'b0000, 3, 4'h7, 7'h12, 1'b1};
    tbl[13] = '{16'h8000, 4'b1000, 4'b1000, 3, 4'h7, 7'h00, 1'b0};
    tbl[14] = '{16'h0B07, 4'hF, 4'b0000, 0, 4'hE, 7'h78, 1'b1};
    tbl[15] = '{16'h0B07, 4'hF, 4'b0000, 2, 4'hB, 7'h03, 1'b1};
    tbl[16] = '{16'h1230, 4'hF, 4'b0000, 0, 4'hE, 7'h40, 1'b1};

    rst   = 1'b1;
    val   = '0;
    en    = '0;
    dp    = '0;
    valid = 1'b0;
    step(3);
    check_output("reset_frame", 32'(frame), 32'd0);
    check_all("reset", 4'hF, 7'h7F, 1'b1);
    rst    = 1'b0;
    mon_on = 1'b1;

    // Idle: nothing displayed, frame pulse every ND*CP cycles.
    wait_frame(k);
    check_output("first_frame_latency", 32'(k), 32'd32);
    wait_frame(k);
    check_output("frame_period", 32'(k), 32'd32);
    goto_slot(0, BC);
    check_all("idle_dark", 4'hF, 7'h7F, 1'b1);

    // Table: load, wait for the update frame, check blanked and visible cycles.
    for (int i = 0; i < 17; i++) begin
      wait_frame(k);
      apply_stimulus(tbl[i].v, tbl[i].e, tbl[i].d);
      wait_frame(k);
      goto_slot(tbl[i].digit, 1);
      check_all($sformatf("vec%0d_blank", i), 4'hF, tbl[i].cat, 1'b1);
      goto_slot(tbl[i].digit, BC);
      check_all($sformatf("vec%0d", i), tbl[i].an, tbl[i].cat, tbl[i].dpo);
    end

    // Two loads in one frame: old value stays up, then only the last appears.
    wait_frame(k);
    apply_stimulus(16'h1111, 4'hF, 4'h0);
    step(3);
    apply_stimulus(16'h2222, 4'hF, 4'h0);
    goto_slot(1, BC);
    check_all("no_tear_old", 4'hD, 7'h30, 1'b1);
    wait_frame(k);
    for (int d = 0; d < ND; d++) begin
      goto_slot(d, BC);
      check_output($sformatf("last_wins_cat%0d", d), 32'(cat), 32'h24);
    end

    // Load on the boundary cycle itself takes effect in the new frame.
    wait_frame(k);
    step(31);
    val   = 16'h3333;
    en    = 4'hF;
    dp    = 4'h0;
    valid = 1'b1;
    step(1);
    valid = 1'b0;
    check_output("frame_at_boundary", 32'(frame), 32'd1);
    pos = 0;
    goto_slot(0, BC);
    check_all("boundary_load", 4'hE, 7'h30, 1'b1);

    // Disabled digits 0 and 2 never light over a whole frame.
    wait_frame(k);
    apply_stimulus(16'h1234, 4'b1010, 4'h0);
    wait_frame(k);
    seen1 = 1'b0;
    for (int c = 0; c < ND * CP; c++) begin
      step(1);
      check_output("an_disabled_off", 32'({an[2], an[0]}), 32'b11);
      if (an == 4'hD) seen1 = 1'b1;
    end
    check_output("an1_seen", 32'(seen1), 32'd1);

    // Leading zeros: only suppressed when the feature is built in.
    wait_frame(k);
    apply_stimulus(16'h0050, 4'hF, 4'h0);
    wait_frame(k);
    goto_slot(0, BC);
    check_all("lz_d0", 4'hE, 7'h40, 1'b1);
    goto_slot(1, BC);
    check_all("lz_d1", 4'hD, 7'h12, 1'b1);
`ifdef LEADING_ZERO_BLANK_EN
    goto_slot(2, BC);
    check_all("lz_d2", 4'hF, 7'h7F, 1'b1);
    goto_slot(3, BC);
    check_all("lz_d3", 4'hF, 7'h7F, 1'b1);
`else
    goto_slot(2, BC);
    check_all("lz_d2", 4'hB, 7'h40, 1'b1);
    goto_slot(3, BC);
    check_all("lz_d3", 4'h7, 7'h40, 1'b1);
`endif

    // Reset mid-frame with an update pending: everything clears, update lost.
    apply_stimulus(16'h9999, 4'hF, 4'hF);
    step(3);
    rst = 1'b1;
    step(1);
    check_output("reset_mid_frame", 32'(frame), 32'd0);
    check_all("reset_mid", 4'hF, 7'h7F, 1'b1);
    rst = 1'b0;
    wait_frame(k);
    check_output("reset_frame_latency", 32'(k), 32'd32);
    goto_slot(0, BC);
    check_all("pending_discarded", 4'hF, 7'h7F, 1'b1);

    mon_on = 1'b0;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
